msr_ctrl: RTL and testbench

MSR_CTRL -- requirements
Module: msr_ctrl

---
 rtl/msr_ctrl.sv | 123 ++++++++++++
 tb/tb_msr_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/msr_ctrl.sv
// Machine-state register with a save/restore copy (SRR1) and a three-state
// interrupt handshake that offers the lowest-index edge-latched pending channel.
module msr_ctrl #(
    parameter int unsigned          MSR_WIDTH = 32,
    parameter logic [MSR_WIDTH-1:0] IMPL_MASK = 32'h0000_9001,
    parameter logic [MSR_WIDTH-1:0] CLR_MASK  = 32'h0000_8000,
    parameter int unsigned          NUM_IRQ   = 4,
    parameter int unsigned          EE_BIT    = 16,
    parameter int unsigned          ME_BIT    = 19,
    parameter int unsigned          LE_BIT    = 31,
    localparam int unsigned         IDW       = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr,
    input  logic [MSR_WIDTH-1:0] wd,
    input  logic                 rfi,
    input  logic [NUM_IRQ-1:0]   irq,
    input  logic                 irq_ready,
    output logic [MSR_WIDTH-1:0] rd,
    output logic [MSR_WIDTH-1:0] srr1,
    output logic                 EE,
    output logic                 ME,
    output logic                 LE,
    output logic                 irq_valid,
    output logic [IDW-1:0]       irq_id,
    output logic [NUM_IRQ-1:0]   pending,
    output logic                 in_handler
);

    // Bit numbers are MSB-0; convert to vector indices.
    localparam int unsigned EE_IDX = MSR_WIDTH - 1 - EE_BIT;
    localparam int unsigned ME_IDX = MSR_WIDTH - 1 - ME_BIT;
    localparam int unsigned LE_IDX = MSR_WIDTH - 1 - LE_BIT;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACTIVE} state_e;

    state_e               state_q, state_d;
    logic [MSR_WIDTH-1:0] msr_q, msr_d;
    logic [MSR_WIDTH-1:0] srr1_q, srr1_d;
    logic [NUM_IRQ-1:0]   pend_q, pend_d;
    logic [NUM_IRQ-1:0]   prev_q;
    logic                 armed_q;
    logic [IDW-1:0]       id_q, id_d;

    logic [NUM_IRQ-1:0]   rise;
    logic [NUM_IRQ-1:0]   clr;
    logic [IDW-1:0]       lowest;
    logic                 found;
    logic                 take;

    always_comb begin
        lowest = '0;
        found  = 1'b0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (!found && pend_q[i]) begin
                lowest = IDW'(i);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        // First cycle after reset only samples irq, so levels held through reset are not edges.
        rise    = armed_q ? (irq & ~prev_q) : '0;
        take    = (state_q == S_REQ) && irq_ready;
        state_d = state_q;
        msr_d   = msr_q;
        srr1_d  = srr1_q;
        id_d    = id_q;
        clr     = '0;

        if (take) begin
            srr1_d  = msr_q;
            msr_d   = msr_q & ~CLR_MASK;
            clr     = NUM_IRQ'(1) << id_q;
            state_d = S_ACTIVE;
        end else if (rfi) begin
            msr_d = srr1_q & IMPL_MASK;
            if (state_q == S_ACTIVE) state_d = S_IDLE;
        end else if (wr) begin
            msr_d = wd & IMPL_MASK;
        end

        if (state_q == S_IDLE && msr_q[EE_IDX] && pend_q != '0) begin
            state_d = S_REQ;
            id_d    = lowest;
        end

        pend_d = (pend_q & ~clr) | rise;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            msr_q   <= '0;
            srr1_q  <= '0;
            pend_q  <= '0;
            prev_q  <= '0;
            armed_q <= 1'b0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            msr_q   <= msr_d;
            srr1_q  <= srr1_d;
            pend_q  <= pend_d;
            prev_q  <= irq;
            armed_q <= 1'b1;
            id_q    <= id_d;
        end
    end

    assign rd         = msr_q;
    assign srr1       = srr1_q;
    assign EE         = msr_q[EE_IDX];
    assign ME         = msr_q[ME_IDX];
    assign LE         = msr_q[LE_IDX];
    assign irq_valid  = (state_q == S_REQ);
    assign irq_id     = id_q;
    assign pending    = pend_q;
    assign in_handler = (state_q == S_ACTIVE);

endmodule

// File: tb/tb_msr_ctrl.sv
// Directed bench for msr_ctrl: each task drives one scenario and checks
// outputs 1 ns after the rising edge against hand-computed values.
module tb_msr_ctrl;

    logic        clk = 1'b0;
    logic        rst, wr, rfi, irq_ready;
    logic [31:0] wd;
    logic [3:0]  irq;
    logic [31:0] rd, srr1;
    logic        EE, ME, LE, irq_valid, in_handler;
    logic [1:0]  irq_id;
    logic [3:0]  pending;

    int errors = 0;
    int checks = 0;

    msr_ctrl #(.MSR_WIDTH(32), .NUM_IRQ(4)) dut (
        .clk(clk), .rst(rst), .wr(wr), .wd(wd), .rfi(rfi), .irq(irq),
        .irq_ready(irq_ready), .rd(rd), .srr1(srr1), .EE(EE), .ME(ME), .LE(LE),
        .irq_valid(irq_valid), .irq_id(irq_id), .pending(pending),
        .in_handler(in_handler)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; wr = 1'b0; wd = '0; rfi = 1'b0; irq = '0; irq_ready = 1'b0;
        step(); step();
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_rd: got %h want %h", rd, 32'h0); end
        checks++; if (srr1 !== 32'h0) begin errors++; $display("FAIL reset_srr1: got %h want %h", srr1, 32'h0); end
        checks++; if ({irq_valid, irq_id, pending, in_handler, EE} !== 9'b0) begin errors++;
            $display("FAIL reset_ctl: got %b want %b", {irq_valid, irq_id, pending, in_handler, EE}, 9'b0); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_write();
        wr = 1'b1; wd = 32'hFFFF_FFFF;
        step();
        wr = 1'b0;
        checks++; if (rd !== 32'h0000_9001) begin errors++; $display("FAIL write_rd: got %h want %h", rd, 32'h0000_9001); end
        checks++; if ({EE, ME, LE} !== 3'b111) begin errors++; $display("FAIL write_bits: got %b want %b", {EE, ME, LE}, 3'b111); end
    endtask

    task automatic test_irq_take();
        irq = 4'b0110;
        step();
        checks++; if (pending !== 4'b0110) begin errors++; $display("FAIL take_pend: got %b want %b", pending, 4'b0110); end
        checks++; if (irq_valid !== 1'b0) begin errors++; $display("FAIL take_early: got %b want %b", irq_valid, 1'b0); end
        step();
        checks++; if ({irq_valid, irq_id} !== 3'b101) begin errors++; $display("FAIL take_req: got %b want %b", {irq_valid, irq_id}, 3'b101); end
        irq_ready = 1'b1;
        step();
        irq_ready = 1'b0;
        checks++; if (srr1 !== 32'h0000_9001) begin errors++; $display("FAIL take_srr1: got %h want %h", srr1, 32'h0000_9001); end
        checks++; if (rd !== 32'h0000_1001) begin errors++; $display("FAIL take_rd: got %h want %h", rd, 32'h0000_1001); end
        checks++; if ({pending, in_handler, irq_valid, EE} !== 7'b0100_100) begin errors++;
            $display("FAIL take_ctl: got %b want %b", {pending, in_handler, irq_valid, EE}, 7'b0100_100); end
    endtask

    task automatic test_rfi();
        rfi = 1'b1;
        step();
        rfi = 1'b0;
        checks++; if (rd !== 32'h0000_9001) begin errors++; $display("FAIL rfi_rd: got %h want %h", rd, 32'h0000_9001); end
        checks++; if ({in_handler, irq_valid} !== 2'b00) begin errors++; $display("FAIL rfi_idle: got %b want %b", {in_handler, irq_valid}, 2'b00); end
        step();
        checks++; if ({irq_valid, irq_id} !== 3'b110) begin errors++; $display("FAIL rfi_next_req: got %b want %b", {irq_valid, irq_id}, 3'b110); end
    endtask

    task automatic test_wr_in_req();
        wr = 1'b1; wd = 32'h0;
        step();
        wr = 1'b0;
        checks++; if ({irq_valid, irq_id} !== 3'b110) begin errors++; $display("FAIL req_hold: got %b want %b", {irq_valid, irq_id}, 3'b110); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL req_wr_rd: got %h want %h", rd, 32'h0); end
        irq_ready = 1'b1;
        step();
        irq_ready = 1'b0;
        checks++; if ({srr1, rd} !== 64'h0) begin errors++; $display("FAIL req_take_regs: got %h want %h", {srr1, rd}, 64'h0); end
        checks++; if ({pending, in_handler} !== 5'b0000_1) begin errors++; $display("FAIL req_take_ctl: got %b want %b", {pending, in_handler}, 5'b0000_1); end
    endtask

    task automatic test_priority();
        rfi = 1'b1;
        step();
        rfi = 1'b0;
        wr = 1'b1; wd = 32'hFFFF_FFFF;
        step();
        wr = 1'b0;
        irq = 4'b0000;
        step();
        irq = 4'b1000;
        step(); step();
        checks++; if ({irq_valid, irq_id} !== 3'b111) begin errors++; $display("FAIL prio_req: got %b want %b", {irq_valid, irq_id}, 3'b111); end
        irq_ready = 1'b1; rfi = 1'b1; wr = 1'b1; wd = 32'h0;
        step();
        irq_ready = 1'b0; rfi = 1'b0; wr = 1'b0;
        checks++; if (srr1 !== 32'h0000_9001) begin errors++; $display("FAIL prio_srr1: got %h want %h", srr1, 32'h0000_9001); end
        checks++; if (rd !== 32'h0000_1001) begin errors++; $display("FAIL prio_rd: got %h want %h", rd, 32'h0000_1001); end
        checks++; if ({pending, in_handler} !== 5'b0000_1) begin errors++; $display("FAIL prio_ctl: got %b want %b", {pending, in_handler}, 5'b0000_1); end
    endtask

    task automatic test_reset_active();
        rst = 1'b1;
        step();
        checks++; if ({rd, srr1} !== 64'h0) begin errors++; $display("FAIL rstact_regs: got %h want %h", {rd, srr1}, 64'h0); end
        checks++; if ({irq_valid, irq_id, pending, in_handler, EE, ME, LE} !== 11'b0) begin errors++;
            $display("FAIL rstact_ctl: got %b want %b", {irq_valid, irq_id, pending, in_handler, EE, ME, LE}, 11'b0); end
        rst = 1'b0;
        step();
        wr = 1'b1; wd = 32'hFFFF_FFFF;
        step();
        wr = 1'b0;
        step(); step();
        checks++; if ({irq_valid, pending} !== 5'b0) begin errors++; $display("FAIL rstact_level: got %b want %b", {irq_valid, pending}, 5'b0); end
        irq = 4'b0000;
        step();
        irq = 4'b1000;
        step();
        checks++; if ({irq_valid, pending} !== 5'b0_1000) begin errors++; $display("FAIL rstact_edge: got %b want %b", {irq_valid, pending}, 5'b0_1000); end
        step();
        checks++; if ({irq_valid, irq_id} !== 3'b111) begin errors++; $display("FAIL rstact_req: got %b want %b", {irq_valid, irq_id}, 3'b111); end
    endtask

    task automatic test_back_to_back();
        irq = 4'b0000;
        step();
        irq = 4'b1000; irq_ready = 1'b1;
        step();
        irq_ready = 1'b0;
        checks++; if ({pending, in_handler} !== 5'b1000_1) begin errors++; $display("FAIL setwins_ctl: got %b want %b", {pending, in_handler}, 5'b1000_1); end
        checks++; if ({srr1, rd} !== {32'h0000_9001, 32'h0000_1001}) begin errors++;
            $display("FAIL setwins_regs: got %h want %h", {srr1, rd}, {32'h0000_9001, 32'h0000_1001}); end
        rfi = 1'b1;
        step();
        rfi = 1'b0;
        step();
        checks++; if ({irq_valid, irq_id, in_handler} !== 4'b1110) begin errors++;
            $display("FAIL b2b_req: got %b want %b", {irq_valid, irq_id, in_handler}, 4'b1110); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_irq_take();
        test_rfi();
        test_wr_in_req();
        test_priority();
        test_reset_active();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
